// File: rtl/xor_unmask_rx.sv
// Receive-side XOR unmasking stage: recovers each masked word with a held key,
// buffers it in a small FIFO and offers it downstream over valid/ready.
module xor_unmask_rx #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [W-1:0]             in_data,
  input  logic                     key_load,
  input  logic [W-1:0]             key,
  input  logic                     clr_ovf,
  output logic                     out_valid,
  output logic [W-1:0]             out_data,
  input  logic                     out_ready,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  key_q;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          pop, full, push, drop;

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    pop     = (level_q != '0) && out_ready;
    full    = (level_q == LW'(DEPTH));
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    push    = in_valid && (!full || pop);
    drop    = in_valid && full && !pop;
    level_d = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
    ovf_d   = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample
  // the pre-edge values (the pushed word uses the key held before a same-cycle load).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (key_load) key_q    <= key;
      if (push)     wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)      rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; level/pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data ^ key_q;
  end

  assign out_valid = (level_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign overflow  = ovf_q;
  assign level     = level_q;

endmodule

// File: tb/tb_xor_unmask_rx.sv
// Randomised plus directed bench for xor_unmask_rx, checked against a queue model.
module tb_xor_unmask_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        key_load = 1'b0;
  logic [15:0] key = '0;
  logic        clr_ovf = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] out_data;
  logic        overflow;
  logic [2:0]  level;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] m_q[$];
  logic [15:0] m_key = '0;
  logic        m_ovf = 1'b0;

  xor_unmask_rx #(.W(16), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .key_load(key_load), .key(key), .clr_ovf(clr_ovf), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .overflow(overflow), .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("valid", 32'(out_valid), 32'(m_q.size() != 0));
    check("level", 32'(level), 32'(m_q.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (m_q.size() != 0) check("data", 32'(out_data), 32'(m_q[0]));
  endtask

  // Applies one cycle of inputs, advances the model and checks after the edge.
  task automatic drive(input logic iv, input logic [15:0] id, input logic kl,
                       input logic [15:0] kv, input logic rdy, input logic clr);
    bit was_full, popped, dropped;
    in_valid = iv; in_data = id; key_load = kl; key = kv; out_ready = rdy; clr_ovf = clr;
    was_full = (m_q.size() == 4);
    popped   = (m_q.size() != 0) && rdy;
    dropped  = iv && was_full && !popped;
    if (popped) void'(m_q.pop_front());
    if (iv && !dropped) m_q.push_back(id ^ m_key);
    if (clr)     m_ovf = 1'b0;
    if (dropped) m_ovf = 1'b1;
    if (kl)      m_key = kv;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; key_load = 1'b0; clr_ovf = 1'b0;
    check_model();
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 16'h0, 1'b0, 16'h0, rdy, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;

    // Mid-stream asynchronous reset with three words buffered.
    drive(1'b1, 16'h0011, 1'b1, 16'h3C3C, 1'b0, 1'b0);
    drive(1'b1, 16'h0022, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(1'b1, 16'h0033, 1'b0, 16'h0, 1'b0, 1'b0);
    check("pre_rst_level", 32'(level), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_level", 32'(level), 32'd0);
    check("async_rst_ovf", 32'(overflow), 32'd0);
    m_q.delete(); m_key = '0; m_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 16'h00FF, 1'b0, 16'h0, 1'b0, 1'b0);
    check("post_rst_data", 32'(out_data), 32'h00FF);
    check("post_rst_valid", 32'(out_valid), 32'd1);
    idle(1'b1);

    // Basic unmask.
    drive(1'b0, 16'h0, 1'b1, 16'h5A5A, 1'b0, 1'b0);
    drive(1'b1, 16'h4B1E, 1'b0, 16'h0, 1'b0, 1'b0);
    check("unmask_data", 32'(out_data), 32'h1144);
    check("unmask_valid", 32'(out_valid), 32'd1);
    check("unmask_level", 32'(level), 32'd1);
    idle(1'b1);
    check("unmask_pop_level", 32'(level), 32'd0);

    // Key load coincident with a push uses the old key.
    drive(1'b0, 16'h0, 1'b1, 16'h0F0F, 1'b0, 1'b0);
    drive(1'b1, 16'h1234, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    drive(1'b1, 16'h1234, 1'b0, 16'h0, 1'b0, 1'b0);
    check("keysw_first", 32'(out_data), 32'h1D3B);
    idle(1'b1);
    check("keysw_second", 32'(out_data), 32'hEDCB);
    idle(1'b1);

    // Fill and overflow.
    drive(1'b0, 16'h0, 1'b1, 16'h0000, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) drive(1'b1, 16'(i), 1'b0, 16'h0, 1'b0, 1'b0);
    check("fill_level", 32'(level), 32'd4);
    check("fill_ovf", 32'(overflow), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      check("drain_head", 32'(out_data), 32'(i));
      idle(1'b1);
    end
    check("drain_empty", 32'(out_valid), 32'd0);
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
    check("clr_ovf", 32'(overflow), 32'd0);

    // Full with simultaneous pop accepts the new word.
    for (int i = 0; i < 4; i++) drive(1'b1, 16'(16'h00A0 + i), 1'b0, 16'h0, 1'b0, 1'b0);
    drive(1'b1, 16'h00AA, 1'b0, 16'h0, 1'b1, 1'b0);
    check("fullpop_level", 32'(level), 32'd4);
    check("fullpop_ovf", 32'(overflow), 32'd0);
    check("fullpop_head", 32'(out_data), 32'h00A1);
    repeat (3) idle(1'b1);
    check("fullpop_tail", 32'(out_data), 32'h00AA);
    idle(1'b1);

    // Random wrap/backpressure stress.
    for (int n = 0; n < 1000; n++) begin
      drive(($urandom % 4) != 0, 16'($urandom), ($urandom % 8) == 0, 16'($urandom),
            ($urandom % 3) == 0, ($urandom % 16) == 0);
    end
    repeat (6) idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
